// File: rtl/nvcp_store_ctrl.sv
// nvcp_store_ctrl: NVRAM store/recall sequencer driving VCORE ramp and VSE1/VSE2 erase/program pulses,
// plus a free-running CLKI/DIV clock with a channel-enable gated copy.
module nvcp_store_ctrl #(
  parameter int NUM_MEM     = 2,
  parameter int DIV         = 4,
  parameter int RAMP_CYCLES = 8,
  parameter int PULSE_BASE  = 16,
  parameter int TRIM_W      = 4
) (
  input  logic               CLKI,
  input  logic               POR,
  input  logic [NUM_MEM-1:0] MEM_ENT,
  input  logic               VSESTART,
  input  logic               RCLT,
  input  logic               BUSYNVC,
  input  logic [TRIM_W-1:0]  TRIM,
  output logic               CLK4,
  output logic               CLK4M,
  output logic               VCORE,
  output logic               VSE1,
  output logic               VSE2,
  output logic               VSEBUSY,
  output logic [NUM_MEM-1:0] SEL,
  output logic               ERR
);
  localparam int PW = $clog2(PULSE_BASE + (1 << TRIM_W));
  localparam int RW = $clog2(RAMP_CYCLES + 1);
  localparam int CW = PW > RW ? PW : RW;
  localparam int DW = DIV > 2 ? $clog2(DIV) : 1;
  typedef enum logic [2:0] {IDLE, RAMP, ERASE, GAP, PROG, DONE} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] p_q, p_d;
  logic [NUM_MEM-1:0] sel_q, sel_d;
  logic clk4_q, clk4_d, clk4m_q, clk4m_d, err_q, err_d, store_q, store_d;
  logic vs_prev_q, rc_prev_q, vs_arm_q, vs_arm_d, rc_arm_q, rc_arm_d;
  logic tick, any_en, vs_rise, rc_rise, req;
  always_comb begin
    any_en   = |MEM_ENT;
    tick     = div_q == DW'(DIV / 2 - 1);
    div_d    = tick ? '0 : div_q + 1'b1;
    clk4_d   = tick ? ~clk4_q : clk4_q;
    clk4m_d  = tick ? ~clk4_q & any_en : clk4m_q;
    // arm flags keep an input held high across POR from looking like a fresh edge
    vs_arm_d = vs_arm_q | ~VSESTART;
    rc_arm_d = rc_arm_q | ~RCLT;
    vs_rise  = VSESTART & ~vs_prev_q & vs_arm_q;
    rc_rise  = RCLT & ~rc_prev_q & rc_arm_q;
    req      = vs_rise | rc_rise;
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    sel_d    = sel_q;
    p_d      = p_q;
    store_d  = store_q;
    err_d    = req & (state_q != IDLE);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req && (BUSYNVC || !any_en)) err_d = 1'b1;
        else if (req) begin
          state_d = RAMP;
          sel_d   = MEM_ENT;
          p_d     = PW'(PULSE_BASE) + PW'(TRIM);
          store_d = vs_rise;
        end
      end
      RAMP: if (cnt_q == CW'(RAMP_CYCLES - 1)) begin
        state_d = store_q ? ERASE : DONE;
        cnt_d   = '0;
      end
      ERASE: if (cnt_q == CW'(p_q - 1'b1)) begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        state_d = PROG;
        cnt_d   = '0;
      end
      PROG: if (cnt_q == CW'(p_q - 1'b1)) begin
        state_d = DONE;
        cnt_d   = '0;
      end
      DONE: begin
        state_d = IDLE;
        sel_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLKI or posedge POR) begin
    if (POR) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      p_q       <= '0;
      sel_q     <= '0;
      clk4_q    <= 1'b0;
      clk4m_q   <= 1'b0;
      err_q     <= 1'b0;
      store_q   <= 1'b0;
      vs_prev_q <= 1'b0;
      rc_prev_q <= 1'b0;
      vs_arm_q  <= 1'b0;
      rc_arm_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      sel_q     <= sel_d;
      clk4_q    <= clk4_d;
      clk4m_q   <= clk4m_d;
      err_q     <= err_d;
      store_q   <= store_d;
      vs_prev_q <= VSESTART;
      rc_prev_q <= RCLT;
      vs_arm_q  <= vs_arm_d;
      rc_arm_q  <= rc_arm_d;
    end
  end
  assign CLK4    = clk4_q;
  assign CLK4M   = clk4m_q;
  assign VCORE   = (state_q == RAMP) | (state_q == ERASE) | (state_q == GAP) | (state_q == PROG);
  assign VSE1    = state_q == ERASE;
  assign VSE2    = state_q == PROG;
  assign VSEBUSY = state_q != IDLE;
  assign SEL     = sel_q;
  assign ERR     = err_q;
endmodule

// File: tb/tb_nvcp_store_ctrl.sv
// tb_nvcp_store_ctrl: directed bench for the store/recall sequencer and clock divider.
module tb_nvcp_store_ctrl;
  logic CLKI = 1'b0, POR = 1'b1;
  logic [1:0] MEM_ENT = 2'b01;
  logic VSESTART = 1'b0, RCLT = 1'b0, BUSYNVC = 1'b0;
  logic [3:0] TRIM = 4'd0;
  logic CLK4, CLK4M, VCORE, VSE1, VSE2, VSEBUSY, ERR;
  logic [1:0] SEL;
  int errors = 0, checks = 0;
  int busy, vpre, v1, gap, v2, bad, errs;
  logic [7:0] pat;
  logic acc;
  nvcp_store_ctrl dut (
    .CLKI(CLKI), .POR(POR), .MEM_ENT(MEM_ENT), .VSESTART(VSESTART), .RCLT(RCLT),
    .BUSYNVC(BUSYNVC), .TRIM(TRIM), .CLK4(CLK4), .CLK4M(CLK4M), .VCORE(VCORE),
    .VSE1(VSE1), .VSE2(VSE2), .VSEBUSY(VSEBUSY), .SEL(SEL), .ERR(ERR)
  );
  always #5 CLKI = ~CLKI;
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // Caller raises the request at a negedge; this samples every following negedge until VSEBUSY falls.
  // mode 1: perturb TRIM/MEM_ENT/BUSYNVC mid-run; mode 2: new VSESTART edge during ERASE.
  task automatic run_op(input logic [1:0] sel_exp, input int mode);
    bit seen1, seen2;
    busy = 0; vpre = 0; v1 = 0; gap = 0; v2 = 0; bad = 0; errs = 0;
    seen1 = 0; seen2 = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLKI);
      if (VSEBUSY) busy++;
      if (ERR) errs++;
      if (VSE1) begin seen1 = 1; v1++; end
      if (VSE2) begin seen2 = 1; v2++; end
      if (VCORE && !VSE1 && !VSE2 && !seen1) vpre++;
      if (VCORE && !VSE1 && !VSE2 && seen1 && !seen2) gap++;
      if ((VSE1 && VSE2) || ((VSE1 || VSE2) && !VCORE)) bad++;
      if (VSEBUSY && SEL !== sel_exp) bad++;
      if (i == 0) begin VSESTART = 0; RCLT = 0; end
      if (mode == 1 && i == 10) begin TRIM = 4'd15; MEM_ENT = 2'b01; BUSYNVC = 1; end
      if (mode == 2 && i == 12) VSESTART = 1;
      if (mode == 2 && i == 14) VSESTART = 0;
      if (busy > 0 && !VSEBUSY) break;
    end
  endtask
  initial begin
    pat = 8'b0110_0110;
    repeat (3) @(negedge CLKI);
    check("reset_outputs", int'({CLK4, CLK4M, VCORE, VSE1, VSE2, VSEBUSY, ERR, SEL}), 0);
    POR = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLKI);
      check($sformatf("clk4_%0d", k), int'(CLK4), int'(pat[k]));
      check($sformatf("clk4m_%0d", k), int'(CLK4M), int'(pat[k]));
    end
    MEM_ENT = 2'b00;
    repeat (4) @(negedge CLKI);
    acc = 0;
    for (int k = 0; k < 8; k++) begin @(negedge CLKI); acc |= CLK4M; end
    check("clk4m_gated_low", int'(acc), 0);
    MEM_ENT = 2'b10;
    @(negedge CLKI);
    VSESTART = 1;
    run_op(2'b10, 0);
    check("st_busy", busy, 42); check("st_vpre", vpre, 8); check("st_vse1", v1, 16);
    check("st_gap", gap, 1); check("st_vse2", v2, 16); check("st_bad", bad, 0);
    check("st_err", errs, 0); check("st_sel_after", int'(SEL), 0);
    TRIM = 4'd5; MEM_ENT = 2'b11;
    @(negedge CLKI);
    VSESTART = 1;
    run_op(2'b11, 1);
    check("trim_busy", busy, 52); check("trim_vse1", v1, 21); check("trim_vse2", v2, 21);
    check("trim_bad", bad, 0); check("trim_err", errs, 0);
    TRIM = 4'd0; MEM_ENT = 2'b01; BUSYNVC = 0;
    @(negedge CLKI);
    RCLT = 1;
    run_op(2'b01, 0);
    check("rc_busy", busy, 9); check("rc_vcore", vpre, 8);
    check("rc_vse", v1 + v2, 0); check("rc_err", errs, 0);
    BUSYNVC = 1;
    @(negedge CLKI); VSESTART = 1;
    @(negedge CLKI); VSESTART = 0;
    check("busynvc_err", int'({ERR, VSEBUSY}), 2);
    @(negedge CLKI);
    check("busynvc_err_once", int'({ERR, VSEBUSY}), 0);
    BUSYNVC = 0; MEM_ENT = 2'b00;
    @(negedge CLKI); VSESTART = 1;
    @(negedge CLKI); VSESTART = 0;
    check("noen_err", int'({ERR, VSEBUSY}), 2);
    @(negedge CLKI);
    check("noen_err_once", int'({ERR, VSEBUSY}), 0);
    MEM_ENT = 2'b10;
    @(negedge CLKI); VSESTART = 1;
    run_op(2'b10, 2);
    check("erase_req_err", errs, 1); check("erase_req_busy", busy, 42);
    check("erase_req_bad", bad, 0);
    @(negedge CLKI); VSESTART = 1; RCLT = 1;
    run_op(2'b10, 0);
    check("both_busy", busy, 42); check("both_vse1", v1, 16); check("both_err", errs, 0);
    @(negedge CLKI); VSESTART = 1;
    repeat (30) begin @(negedge CLKI); VSESTART = 0; end
    check("pre_por_prog", int'(VSE2), 1);
    #2 POR = 1;
    #1 check("por_async", int'({CLK4, CLK4M, VCORE, VSE1, VSE2, VSEBUSY, ERR, SEL}), 0);
    VSESTART = 1;
    @(negedge CLKI); POR = 0;
    repeat (6) @(negedge CLKI);
    check("held_start_ignored", int'({VSEBUSY, ERR}), 0);
    VSESTART = 0;
    @(negedge CLKI); VSESTART = 1;
    run_op(2'b10, 0);
    check("post_por_busy", busy, 42); check("post_por_vse2", v2, 16); check("post_por_bad", bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nvcp_store_ctrl.md
NVCP_STORE_CTRL -- requirements
Module: nvcp_store_ctrl

Interface
REQ-001 Parameter NUM_MEM, default 2: number of NVRAM macros (channels) served.
REQ-002 Parameter DIV, default 4: CLKI-to-CLK4 divide ratio; even, >= 2.
REQ-003 Parameter RAMP_CYCLES, default 8: VCORE ramp time in CLKI cycles, >= 1.
REQ-004 Parameter PULSE_BASE, default 16: base VSE1/VSE2 pulse width in CLKI cycles, >= 1.
REQ-005 Parameter TRIM_W, default 4: width of pulse-trim input.
REQ-006 CLKI  input  1  sole clock; all state updates on its rising edge.
REQ-007 POR  input  1  reset; asynchronous, active-high.
REQ-008 MEM_ENT  input  NUM_MEM  per-channel enable from NVRAM macros.
REQ-009 VSESTART  input  1  store request; rising edge significant.
REQ-010 RCLT  input  1  recall request; rising edge significant.
REQ-011 BUSYNVC  input  1  NV controller busy; requests rejected while high.
REQ-012 TRIM  input  TRIM_W  unsigned pulse extension, sampled at request acceptance.
REQ-013 CLK4  output  1  divided clock, CLKI/DIV, 50% duty.
REQ-014 CLK4M  output  1  CLK4 gated by any enabled channel.
REQ-015 VCORE  output  1  core pump enable.
REQ-016 VSE1, VSE2  output  1 each  erase/program phase enables.
REQ-017 VSEBUSY  output  1  operation in progress.
REQ-018 SEL  output  NUM_MEM  channel mask latched at acceptance.
REQ-019 ERR  output  1  one-cycle pulse on rejected request.

Function
REQ-020 CLK4 SHALL be a free-running registered divider: low out of reset, toggling every DIV/2 CLKI cycles, first rise after DIV/2 rising edges.
REQ-021 CLK4M SHALL equal CLK4 while |MEM_ENT=1 and be held low otherwise, registered, glitch-free, changing only at CLK4 toggle points.
REQ-022 Rising edges of VSESTART/RCLT SHALL be detected against a registered previous value.
REQ-023 A request SHALL be accepted only in IDLE with BUSYNVC=0 and |MEM_ENT=1; else ERR pulses high for exactly one cycle and state is unchanged.
REQ-024 Requests arriving while not IDLE SHALL be ignored and SHALL pulse ERR.
REQ-025 Simultaneous VSESTART and RCLT edges SHALL accept the store; RCLT is dropped without ERR.
REQ-026 On acceptance: SEL<=MEM_ENT, pulse length P<=PULSE_BASE+TRIM (width sufficient for no overflow), VSEBUSY and VCORE high from the next cycle.
REQ-027 FSM states: IDLE, RAMP, ERASE, GAP, PROG, DONE.
REQ-028 RAMP: VCORE=1 for RAMP_CYCLES cycles; then ERASE (store) or DONE (recall).
REQ-029 ERASE: VCORE=1, VSE1=1 for P cycles, then GAP.
REQ-030 GAP: VCORE=1, VSE1=VSE2=0 for 1 cycle, then PROG.
REQ-031 PROG: VCORE=1, VSE2=1 for P cycles, then DONE.
REQ-032 DONE: VCORE=VSE1=VSE2=0, VSEBUSY=1 for 1 cycle, then IDLE with VSEBUSY=0, SEL=0.
REQ-033 VSE1 and VSE2 SHALL never be high together; neither SHALL be high while VCORE=0.
REQ-034 Changes to MEM_ENT, TRIM, BUSYNVC mid-operation SHALL not affect the running sequence or SEL.
REQ-035 Total store busy = RAMP_CYCLES+2P+2 cycles; recall busy = RAMP_CYCLES+1 cycles.

Reset
REQ-036 POR=1 SHALL immediately force IDLE; CLK4, CLK4M, VCORE, VSE1, VSE2, VSEBUSY, ERR low; SEL=0; counters and edge registers cleared.
REQ-037 POR asserted mid-operation SHALL abort without completing; after release a VSESTART held high SHALL not trigger until it falls and rises again.

Verification (defaults)
REQ-038 POR release, MEM_ENT=01 -> CLK4 period 4 CLKI, CLK4M follows CLK4; MEM_ENT=00 -> CLK4M held low.
REQ-039 VSESTART edge, TRIM=0, MEM_ENT=10 -> VSEBUSY 42 cycles, VCORE 8 cycles before VSE1 16, gap 1, VSE2 16, SEL=10 throughout.
REQ-040 VSESTART edge, TRIM=5 -> VSE1 and VSE2 each 21 cycles, VSEBUSY 52 cycles; TRIM change mid-sequence -> no effect.
REQ-041 RCLT edge -> VCORE 8 cycles, VSE1/VSE2 never high, VSEBUSY 9 cycles.
REQ-042 VSESTART with BUSYNVC=1, or MEM_ENT=00, or during ERASE -> single-cycle ERR, no state change; VSESTART+RCLT same cycle -> store sequence, no ERR.
REQ-043 POR pulse during PROG -> all outputs low immediately, IDLE; next clean VSESTART edge -> full 42-cycle store.
